qdec_nal_epb_filter: RTL and testbench
======================================

Name: qdec_nal_epb_filter

Overview:
- Byte-stream pre-processor directly upstream of the CABAC arithmetic decoder's bitstream fetch port.
- Consumes raw Annex-B bytes from the bitstream RAM reader.
- Locates start codes, discards start-code prefixes and trailing zeros, and strips emulation-prevention bytes (0x03 after 00 00).
- Emits clean RBSP bytes on a valid/ready interface that connects straight to bitstreamFetch/_vld/_rdy.

Parameters:
- ZCNT_W, 8, width of saturating held-zero counter.
- EPB_CNT_W, 16, width of removed-EPB statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- raw_byte  in  8  raw Annex-B byte
- raw_vld  in  1  raw byte valid
- raw_last  in  1  qualifies raw_byte as last byte of the buffer
- raw_rdy  out  1  filter accepts raw byte
- out_byte  out  8  RBSP byte (to bitstreamFetch)
- out_vld  out  1  out_byte valid
- out_rdy  in  1  downstream accepts
- out_sof  out  1  out_byte is first byte after a start code
- nal_start  out  1  one-cycle pulse when a start code completes
- nal_end  out  1  one-cycle pulse when raw_last is consumed
- epb_cnt  out  EPB_CNT_W  EPBs removed since reset, saturating
- err_forbidden  out  1  sticky: illegal 00 00 0x sequence seen

Behaviour:
- Reset values: all outputs 0; state SEEK; zcnt=0; raw_rdy=0 during reset cycle.
- Raw transfer occurs when raw_vld&&raw_rdy. Output transfer occurs when out_vld&&out_rdy.
- Output stage is a single register. out_vld/out_byte/out_sof hold stable until accepted.
- raw_rdy = (state!=FLUSH) && (!out_vld || out_rdy).
- State SEEK: drop all bytes and track zcnt.
  - Byte 00 increments zcnt, saturating at 2^ZCNT_W-1.
  - Byte 01 with zcnt>=2 → pulse nal_start, set sof_pend, go PASS, zcnt=0.
  - Any other byte → zcnt=0.
- State PASS, per accepted byte b:
  - b==00: zcnt++ (saturating). Byte is held, not emitted.
  - b==01 && zcnt>=2: start code. Discard held zeros (trailing_zero_8bits), pulse nal_start, set sof_pend, zcnt=0.
  - b==03 && zcnt==2: EPB. Emit 2 zeros via FLUSH, drop the 03, epb_cnt++, zcnt=0. The byte following an EPB is never compared against the EPB rule using zeros from before the EPB.
  - b==03 && zcnt>2, or b==02 && zcnt>=2: set err_forbidden, then treat b as data.
  - Otherwise, zcnt==0: load b into the output register next cycle (1-cycle latency). out_sof=sof_pend, then clear sof_pend.
  - Otherwise, zcnt>0: latch b into pend_byte, go FLUSH.
- State FLUSH:
  - Emit zcnt zeros, one per output transfer; the first zero carries out_sof if sof_pend.
  - Then emit pend_byte (unless the flush came from an EPB, in which case nothing follows), return to PASS, zcnt=0.
  - raw_rdy=0 throughout.
- raw_last:
  - Processed as a normal byte first.
  - Any zeros still held afterwards are discarded.
  - nal_end pulses in the cycle after acceptance (after FLUSH completes if FLUSH was entered).
  - State returns to SEEK.
- Simultaneous events:
  - nal_start and output-transfer handshakes are independent.
  - The pulse is produced on the accepting cycle's registered edge even while out_vld stalls.
- epb_cnt saturates at all-ones. err_forbidden clears only on rst.
- Reset mid-operation: state, counters, and the output register are cleared the next edge. A pending byte is lost.

Optional Feature:
- Macro QDEC_NAL_HDR_STRIP_EN.
- When defined:
  - The first two RBSP bytes after each start code are consumed internally, not emitted.
  - Adds outputs nal_unit_type[5:0], nuh_layer_id[5:0], temporal_id[2:0] (= tid_plus1-1), registered and valid from the cycle after the second header byte.
  - forbidden_zero_bit==1 sets err_forbidden.
  - out_sof marks the third byte.
- When undefined: header bytes pass through as data and the ports are absent.

Test Plan:
- Feed 00 00 00 01 40 01 AA BB, out_rdy=1 → nal_start pulses once; out bytes 40,01,AA,BB; out_sof only on 40; epb_cnt=0.
- Feed 00 00 01 12 00 00 03 01 55 → outputs 12,00,00,01,55; epb_cnt=1; err_forbidden=0.
- Feed 00 00 01 7E 00 00 02 → err_forbidden=1 and stays 1 across further traffic until rst.
- Feed 00 00 01 AB 00 00 00 00 01 CD with raw_last on CD → AB, then CD with out_sof=1; two nal_start pulses; nal_end after CD; no zeros emitted.
- Same as test 2 with out_rdy toggling 1-0-0-1 → identical byte sequence; out_byte stable whenever out_vld&&!out_rdy; no byte dropped or duplicated.
- Assert rst while in FLUSH with 3 zeros held → next cycle out_vld=0, epb_cnt=0, state SEEK; a following 00 00 01 33 yields 33 with out_sof=1.

Source files
------------

// File: rtl/qdec_nal_epb_filter.sv
// qdec_nal_epb_filter
// Annex-B byte-stream pre-processor that sits in front of the CABAC
// bitstream fetch port. It finds start codes, drops the start-code prefixes
// and trailing zeros, removes emulation-prevention bytes (00 00 03), and
// delivers clean RBSP bytes on a valid/ready interface.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   raw_byte/raw_vld/raw_last      raw Annex-B input, raw_rdy is its ready
//   out_byte/out_vld/out_sof       RBSP output register, out_rdy is its ready
//   nal_start                      pulse when a start code completes
//   nal_end                        pulse after the byte marked raw_last is done
//   epb_cnt                        saturating count of removed EPBs
//   err_forbidden                  sticky flag for illegal 00 00 0x sequences
//
// Optional build macro QDEC_NAL_HDR_STRIP_EN: the two NAL header bytes after
// each start code are consumed internally and decoded onto nal_unit_type,
// nuh_layer_id and temporal_id instead of being emitted.
module qdec_nal_epb_filter #(
  parameter int ZCNT_W    = 8,
  parameter int EPB_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           raw_byte,
  input  logic                 raw_vld,
  input  logic                 raw_last,
  output logic                 raw_rdy,
  output logic [7:0]           out_byte,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_sof,
  output logic                 nal_start,
  output logic                 nal_end,
  output logic [EPB_CNT_W-1:0] epb_cnt,
  output logic                 err_forbidden
`ifdef QDEC_NAL_HDR_STRIP_EN
  ,
  output logic [5:0]           nal_unit_type,
  output logic [5:0]           nuh_layer_id,
  output logic [2:0]           temporal_id
`endif
);

  typedef enum logic [1:0] {SEEK, PASS, FLUSH} state_e;

  localparam logic [ZCNT_W-1:0] ZMAX = '1;
  localparam logic [ZCNT_W-1:0] ZTWO = ZCNT_W'(2);

  state_e                 state_q, state_d;
  logic [ZCNT_W-1:0]      zcnt_q, zcnt_d;
  logic                   sof_pend_q, sof_pend_d;
  logic [7:0]             pend_byte_q, pend_byte_d;
  logic                   pend_vld_q, pend_vld_d;   // a data byte follows the zeros
  logic                   last_q, last_d;           // flush was entered by the last byte
  logic [7:0]             out_byte_q, out_byte_d;
  logic                   out_vld_q, out_vld_d;
  logic                   out_sof_q, out_sof_d;
  logic                   nal_start_q, nal_start_d;
  logic                   nal_end_q, nal_end_d;
  logic [EPB_CNT_W-1:0]   epb_cnt_q, epb_cnt_d;
  logic                   err_q, err_d;

  logic                   slot_free, raw_fire, emit_en, strip, flush_done;
  logic [7:0]             emit_byte;
  logic [ZCNT_W-1:0]      zcnt_inc;

`ifdef QDEC_NAL_HDR_STRIP_EN
  logic [1:0]             hdr_left_q, hdr_left_d;
  logic [5:0]             nut_q, nut_d;
  logic [5:0]             layer_q, layer_d;
  logic [2:0]             tid_q, tid_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEEK;
      zcnt_q      <= '0;
      sof_pend_q  <= 1'b0;
      pend_byte_q <= 8'h00;
      pend_vld_q  <= 1'b0;
      last_q      <= 1'b0;
      out_byte_q  <= 8'h00;
      out_vld_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      nal_start_q <= 1'b0;
      nal_end_q   <= 1'b0;
      epb_cnt_q   <= '0;
      err_q       <= 1'b0;
`ifdef QDEC_NAL_HDR_STRIP_EN
      hdr_left_q  <= 2'd0;
      nut_q       <= 6'd0;
      layer_q     <= 6'd0;
      tid_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      zcnt_q      <= zcnt_d;
      sof_pend_q  <= sof_pend_d;
      pend_byte_q <= pend_byte_d;
      pend_vld_q  <= pend_vld_d;
      last_q      <= last_d;
      out_byte_q  <= out_byte_d;
      out_vld_q   <= out_vld_d;
      out_sof_q   <= out_sof_d;
      nal_start_q <= nal_start_d;
      nal_end_q   <= nal_end_d;
      epb_cnt_q   <= epb_cnt_d;
      err_q       <= err_d;
`ifdef QDEC_NAL_HDR_STRIP_EN
      hdr_left_q  <= hdr_left_d;
      nut_q       <= nut_d;
      layer_q     <= layer_d;
      tid_q       <= tid_d;
`endif
    end
  end

  assign slot_free = !out_vld_q || out_rdy;
  assign raw_fire  = raw_vld && raw_rdy;
  assign zcnt_inc  = (zcnt_q == ZMAX) ? zcnt_q : zcnt_q + ZCNT_W'(1);

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    zcnt_d      = zcnt_q;
    sof_pend_d  = sof_pend_q;
    pend_byte_d = pend_byte_q;
    pend_vld_d  = pend_vld_q;
    last_d      = last_q;
    epb_cnt_d   = epb_cnt_q;
    err_d       = err_q;
    nal_start_d = 1'b0;
    nal_end_d   = 1'b0;
    emit_en     = 1'b0;
    emit_byte   = raw_byte;
    flush_done  = 1'b0;
    strip       = 1'b0;
`ifdef QDEC_NAL_HDR_STRIP_EN
    hdr_left_d  = hdr_left_q;
    nut_d       = nut_q;
    layer_d     = layer_q;
    tid_d       = tid_q;
`endif

    case (state_q)
      SEEK: begin
        if (raw_fire) begin
          if (raw_byte == 8'h00) begin
            zcnt_d = zcnt_inc;
          end else if (raw_byte == 8'h01 && zcnt_q >= ZTWO) begin
            nal_start_d = 1'b1;
            sof_pend_d  = 1'b1;
            zcnt_d      = '0;
            state_d     = raw_last ? SEEK : PASS;
`ifdef QDEC_NAL_HDR_STRIP_EN
            hdr_left_d  = 2'd2;
`endif
          end else begin
            zcnt_d = '0;
          end
          if (raw_last) begin
            zcnt_d    = '0;
            nal_end_d = 1'b1;
          end
        end
      end

      PASS: begin
        if (raw_fire) begin
          if (raw_byte == 8'h00) begin
            // Zeros are held until we know whether they start a start code,
            // precede an EPB, or are real data.
            if (raw_last) begin
              zcnt_d    = '0;
              state_d   = SEEK;
              nal_end_d = 1'b1;
            end else begin
              zcnt_d = zcnt_inc;
            end
          end else if (raw_byte == 8'h01 && zcnt_q >= ZTWO) begin
            // Start code: held zeros were trailing_zero_8bits, drop them.
            nal_start_d = 1'b1;
            sof_pend_d  = 1'b1;
            zcnt_d      = '0;
`ifdef QDEC_NAL_HDR_STRIP_EN
            hdr_left_d  = 2'd2;
`endif
            if (raw_last) begin
              state_d   = SEEK;
              nal_end_d = 1'b1;
            end
          end else if (raw_byte == 8'h03 && zcnt_q == ZTWO) begin
            // EPB: replay the two zeros, drop the 03 itself.
            if (epb_cnt_q != '1) epb_cnt_d = epb_cnt_q + EPB_CNT_W'(1);
            pend_vld_d = 1'b0;
            last_d     = raw_last;
            state_d    = FLUSH;
          end else begin
            if ((raw_byte == 8'h03 && zcnt_q > ZTWO) ||
                (raw_byte == 8'h02 && zcnt_q >= ZTWO)) begin
              err_d = 1'b1;
            end
            if (zcnt_q == '0) begin
              emit_en   = 1'b1;
              emit_byte = raw_byte;
              if (raw_last) begin
                state_d   = SEEK;
                nal_end_d = 1'b1;
              end
            end else begin
              pend_byte_d = raw_byte;
              pend_vld_d  = 1'b1;
              last_d      = raw_last;
              state_d     = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        if (slot_free) begin
          emit_en = 1'b1;
          if (zcnt_q != '0) begin
            emit_byte  = 8'h00;
            zcnt_d     = zcnt_q - ZCNT_W'(1);
            // An EPB flush has nothing after its zeros, so leave on the last one.
            flush_done = (zcnt_q == ZCNT_W'(1)) && !pend_vld_q;
          end else begin
            emit_byte  = pend_byte_q;
            flush_done = 1'b1;
          end
          if (flush_done) begin
            zcnt_d     = '0;
            pend_vld_d = 1'b0;
            last_d     = 1'b0;
            state_d    = last_q ? SEEK : PASS;
            nal_end_d  = last_q;
          end
        end
      end

      default: state_d = SEEK;
    endcase

`ifdef QDEC_NAL_HDR_STRIP_EN
    strip = (hdr_left_q != 2'd0);
    if (emit_en && strip) begin
      // Header bytes are decoded here; sof_pend stays set for the first payload byte.
      hdr_left_d = hdr_left_q - 2'd1;
      if (hdr_left_q == 2'd2) begin
        nut_d      = emit_byte[6:1];
        layer_d[5] = emit_byte[0];
        if (emit_byte[7]) err_d = 1'b1;
      end else begin
        layer_d[4:0] = emit_byte[7:3];
        tid_d        = emit_byte[2:0] - 3'd1;
      end
    end
`endif

    // Output register: holds until accepted, reloads only when a byte is emitted.
    out_vld_d  = out_vld_q && !out_rdy;
    out_byte_d = out_byte_q;
    out_sof_d  = out_sof_q;
    if (emit_en && !strip) begin
      out_vld_d  = 1'b1;
      out_byte_d = emit_byte;
      out_sof_d  = sof_pend_q;
      sof_pend_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    raw_rdy = !rst && (state_q != FLUSH) && slot_free;
  end

  assign out_byte      = out_byte_q;
  assign out_vld       = out_vld_q;
  assign out_sof       = out_sof_q;
  assign nal_start     = nal_start_q;
  assign nal_end       = nal_end_q;
  assign epb_cnt       = epb_cnt_q;
  assign err_forbidden = err_q;
`ifdef QDEC_NAL_HDR_STRIP_EN
  assign nal_unit_type = nut_q;
  assign nuh_layer_id  = layer_q;
  assign temporal_id   = tid_q;
`endif

endmodule

// File: tb/tb_qdec_nal_epb_filter.sv
// Directed bench for qdec_nal_epb_filter (default build, header strip off).
module tb_qdec_nal_epb_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  raw_byte;
  logic        raw_vld;
  logic        raw_last;
  logic        raw_rdy;
  logic [7:0]  out_byte;
  logic        out_vld;
  logic        out_rdy;
  logic        out_sof;
  logic        nal_start;
  logic        nal_end;
  logic [15:0] epb_cnt;
  logic        err_forbidden;
`ifdef QDEC_NAL_HDR_STRIP_EN
  logic [5:0]  nal_unit_type;
  logic [5:0]  nuh_layer_id;
  logic [2:0]  temporal_id;
`endif

  qdec_nal_epb_filter #(.ZCNT_W(8), .EPB_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_byte      (raw_byte),
    .raw_vld       (raw_vld),
    .raw_last      (raw_last),
    .raw_rdy       (raw_rdy),
    .out_byte      (out_byte),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_sof       (out_sof),
    .nal_start     (nal_start),
    .nal_end       (nal_end),
    .epb_cnt       (epb_cnt),
    .err_forbidden (err_forbidden)
`ifdef QDEC_NAL_HDR_STRIP_EN
    ,
    .nal_unit_type (nal_unit_type),
    .nuh_layer_id  (nuh_layer_id),
    .temporal_id   (temporal_id)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got_b[$];
  logic       got_s[$];
  int         ns_cnt;
  int         ne_cnt;
  logic [7:0] ne_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    raw_vld  = 1'b0;
    raw_last = 1'b0;
    raw_byte = 8'h00;
    out_rdy  = 1'b0;
    #1;
    check("rst_raw_rdy", {31'd0, raw_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_epb_cnt", {16'd0, epb_cnt}, 32'd0);
    check("rst_err", {31'd0, err_forbidden}, 32'd0);
    check("rst_pulses", {30'd0, nal_start, nal_end}, 32'd0);
  endtask

  // Feed n bytes (first byte most significant in bv), collecting every output
  // transfer. mode 0: out_rdy=1, 1: out_rdy pattern 1-0-0-1, 2: out_rdy=0.
  task automatic run(input int n, input logic [127:0] bv, input int last_idx,
                     input int mode, input int tail);
    int         idx = 0;
    int         cyc = 0;
    int         idle = 0;
    logic       pv = 1'b0;
    logic [7:0] pb = 8'h00;
    got_b.delete();
    got_s.delete();
    ns_cnt  = 0;
    ne_cnt  = 0;
    ne_byte = 8'h00;
    while ((idx < n || idle < tail) && cyc < 400) begin
      @(negedge clk);
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_rdy = 1'b0;
      endcase
      if (idx < n) begin
        raw_vld  = 1'b1;
        raw_byte = bv[8*(n-1-idx) +: 8];
        raw_last = (idx == last_idx);
      end else begin
        raw_vld  = 1'b0;
        raw_byte = 8'h00;
        raw_last = 1'b0;
        idle++;
      end
      #1;
      if (pv) check("stall_stable", {23'd0, out_vld, out_byte}, {23'd0, 1'b1, pb});
      pv = out_vld && !out_rdy;
      pb = out_byte;
      if (out_vld && out_rdy) begin
        got_b.push_back(out_byte);
        got_s.push_back(out_sof);
      end
      if (nal_start) ns_cnt++;
      if (nal_end) begin
        ne_cnt++;
        ne_byte = out_vld ? out_byte : 8'h00;
      end
      if (raw_vld && raw_rdy) idx++;
      cyc++;
    end
    if (idx < n) check("feed_timeout", idx, n);
    raw_vld  = 1'b0;
    raw_last = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int n, input logic [127:0] bv,
                            input logic [15:0] sm);
    check($sformatf("%s_count", tag), got_b.size(), n);
    for (int i = 0; i < n && i < got_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got_b[i]}, {24'd0, bv[8*(n-1-i) +: 8]});
      check($sformatf("%s_sof%0d", tag, i), {31'd0, got_s[i]}, {31'd0, sm[i]});
    end
  endtask

  initial begin
    rst      = 1'b1;
    raw_vld  = 1'b0;
    raw_last = 1'b0;
    raw_byte = 8'h00;
    out_rdy  = 1'b0;

    // Basic start code with a 4-byte NAL
    do_reset();
    run(8, 128'h00000001_4001AABB, -1, 0, 8);
    expect_out("t1", 4, 128'h4001AABB, 16'h0001);
    check("t1_nal_start", ns_cnt, 1);
    check("t1_epb", {16'd0, epb_cnt}, 0);
    $display("t1 basic: %0d bytes out", got_b.size());

    // EPB removal
    do_reset();
    run(9, 128'h000001_120000_030155, -1, 0, 8);
    expect_out("t2", 5, 128'h12_0000_0155, 16'h0001);
    check("t2_epb", {16'd0, epb_cnt}, 1);
    check("t2_err", {31'd0, err_forbidden}, 0);
    $display("t2 epb: %0d bytes out, epb_cnt=%0d", got_b.size(), epb_cnt);

    // Forbidden 00 00 02, sticky across further traffic
    do_reset();
    run(7, 128'h000001_7E0000_02, -1, 0, 8);
    expect_out("t3", 4, 128'h7E000002, 16'h0001);
    check("t3_err", {31'd0, err_forbidden}, 1);
    run(5, 128'h000001_1122, -1, 0, 8);
    expect_out("t3b", 2, 128'h1122, 16'h0001);
    check("t3_err_sticky", {31'd0, err_forbidden}, 1);
    $display("t3 forbidden 02: err_forbidden=%0d", err_forbidden);

    // Trailing zeros + second start code, raw_last on CD
    do_reset();
    run(10, 128'h000001_AB_00000000_01_CD, 9, 0, 8);
    expect_out("t4", 2, 128'hABCD, 16'h0003);
    check("t4_nal_start", ns_cnt, 2);
    check("t4_nal_end", ne_cnt, 1);
    check("t4_nal_end_byte", {24'd0, ne_byte}, 32'hCD);
    $display("t4 trailing zeros: %0d bytes out, %0d starts", got_b.size(), ns_cnt);

    // EPB stream with output back-pressure
    do_reset();
    run(9, 128'h000001_120000_030155, -1, 1, 16);
    expect_out("t5", 5, 128'h12_0000_0155, 16'h0001);
    check("t5_epb", {16'd0, epb_cnt}, 1);
    $display("t5 backpressure: %0d bytes out", got_b.size());

    // raw_last on a held zero: zeros discarded
    do_reset();
    run(6, 128'h000001_AB_0000, 5, 0, 8);
    expect_out("t6", 1, 128'hAB, 16'h0001);
    check("t6_nal_end", ne_cnt, 1);
    $display("t6 last on zero: %0d bytes out", got_b.size());

    // raw_last on data behind held zeros: nal_end after the flush
    do_reset();
    run(6, 128'h000001_11_00_22, 5, 0, 8);
    expect_out("t7", 3, 128'h11_00_22, 16'h0001);
    check("t7_nal_end", ne_cnt, 1);
    check("t7_nal_end_byte", {24'd0, ne_byte}, 32'h22);
    $display("t7 last after flush: %0d bytes out", got_b.size());

    // 03 after three zeros is forbidden data, not an EPB
    do_reset();
    run(8, 128'h000001_11_000000_03, -1, 0, 8);
    expect_out("t8", 5, 128'h11_000000_03, 16'h0001);
    check("t8_err", {31'd0, err_forbidden}, 1);
    check("t8_epb", {16'd0, epb_cnt}, 0);
    $display("t8 00 00 00 03: err_forbidden=%0d", err_forbidden);

    // Reset while flushing three held zeros
    do_reset();
    run(9, 128'h000001_120000_030155, -1, 0, 8);
    check("t9_epb_pre", {16'd0, epb_cnt}, 1);
    run(4, 128'h000000_55, -1, 2, 3);
    check("t9_stalled_vld", {31'd0, out_vld}, 1);
    check("t9_stalled_byte", {24'd0, out_byte}, 32'h00);
    check("t9_flush_rdy", {31'd0, raw_rdy}, 0);
    do_reset();
    run(5, 128'h33_000001_33, -1, 0, 8);
    expect_out("t9", 1, 128'h33, 16'h0001);
    $display("t9 reset in flush: %0d bytes out", got_b.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
